// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: configurable UART receiver with a 2-flop line synchroniser,
// optional parity, 1 or 2 stop bits, and a valid/ready output holding
// register that flags overrun when a frame arrives while one is still held.
module uart_rx_cfg #(
  parameter int CLOCK_FREQ = 50000000,
  parameter int BAUD_RATE  = 9600,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 data_in,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int CLKS_PER_BIT = CLOCK_FREQ / BAUD_RATE;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);
  localparam int IDX_W        = $clog2(DATA_BITS);

  localparam logic [CNT_W-1:0] SAMPLE_CNT = CNT_W'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CNT_W-1:0] END_CNT    = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(DATA_BITS - 1);
  localparam logic             LAST_STOP  = 1'(STOP_BITS - 1);
  localparam logic             ODD_MODE   = (PARITY == 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t                 state_q, state_d;
  logic                   sync1_q, sync1_d;
  logic                   sync2_q, sync2_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0]       bit_idx_q, bit_idx_d;
  logic                   stop_idx_q, stop_idx_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   perr_pend_q, perr_pend_d;
  logic                   ferr_pend_q, ferr_pend_d;
  logic [DATA_BITS-1:0]   rx_data_q, rx_data_d;
  logic                   rx_valid_q, rx_valid_d;
  logic                   parity_err_q, parity_err_d;
  logic                   frame_err_q, frame_err_d;
  logic                   overrun_q, overrun_d;

  logic line;
  logic sample_tick;
  logic bit_end;
  logic commit;

  assign line        = sync2_q;
  assign sample_tick = (cnt_q == SAMPLE_CNT);
  assign bit_end     = (cnt_q == END_CNT);

  // Next-state: synchroniser, bit timing, frame FSM and output holding register.
  always_comb begin
    state_d      = state_q;
    sync1_d      = data_in;
    sync2_d      = sync1_q;
    cnt_d        = cnt_q;
    bit_idx_d    = bit_idx_q;
    stop_idx_d   = stop_idx_q;
    shift_d      = shift_q;
    perr_pend_d  = perr_pend_q;
    ferr_pend_d  = ferr_pend_q;
    rx_data_d    = rx_data_q;
    rx_valid_d   = rx_valid_q;
    parity_err_d = parity_err_q;
    frame_err_d  = frame_err_q;
    overrun_d    = overrun_q;
    commit       = 1'b0;

    if (state_q != S_IDLE) begin
      cnt_d = bit_end ? '0 : cnt_q + 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        // Counter is parked at 0 so the start bit is timed from its edge.
        cnt_d       = '0;
        bit_idx_d   = '0;
        stop_idx_d  = 1'b0;
        perr_pend_d = 1'b0;
        ferr_pend_d = 1'b0;
        if (!line) state_d = S_START;
      end
      S_START: begin
        if (sample_tick && line) begin
          // Line went back high before mid-bit: treat as a glitch.
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (bit_end) begin
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (sample_tick) shift_d[bit_idx_q] = line;
        if (bit_end) begin
          if (bit_idx_q == LAST_IDX) begin
            bit_idx_d = '0;
            state_d   = (PARITY != 0) ? S_PARITY : S_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end
      end
      S_PARITY: begin
        // XOR of data and parity bit is 1 for an odd count of ones.
        if (sample_tick) perr_pend_d = ((^shift_q) ^ line) != ODD_MODE;
        if (bit_end) state_d = S_STOP;
      end
      S_STOP: begin
        if (sample_tick) begin
          if (!line) ferr_pend_d = 1'b1;
          if (stop_idx_q == LAST_STOP) begin
            // Final stop bit: commit at mid-bit so a back-to-back start edge is not missed.
            state_d = S_IDLE;
            cnt_d   = '0;
            commit  = 1'b1;
          end
        end
        if (bit_end) stop_idx_d = 1'b1;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    if (commit) begin
      if (!rx_valid_q || rx_ready) begin
        rx_data_d    = shift_q;
        parity_err_d = perr_pend_q;
        frame_err_d  = ferr_pend_q | ~line;
        rx_valid_d   = 1'b1;
        overrun_d    = 1'b0;
      end else begin
        // Consumer still holds the previous frame: drop this one.
        overrun_d = 1'b1;
      end
    end else if (rx_valid_q && rx_ready) begin
      rx_valid_d = 1'b0;
      overrun_d  = 1'b0;
    end
  end

  // State registers with asynchronous reset; synchroniser resets to idle-high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      sync1_q      <= 1'b1;
      sync2_q      <= 1'b1;
      cnt_q        <= '0;
      bit_idx_q    <= '0;
      stop_idx_q   <= 1'b0;
      shift_q      <= '0;
      perr_pend_q  <= 1'b0;
      ferr_pend_q  <= 1'b0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      cnt_q        <= cnt_d;
      bit_idx_q    <= bit_idx_d;
      stop_idx_q   <= stop_idx_d;
      shift_q      <= shift_d;
      perr_pend_q  <= perr_pend_d;
      ferr_pend_q  <= ferr_pend_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
    end
  end

  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;
  assign busy       = (state_q != S_IDLE);

endmodule

// File: doc/uart_rx_cfg.md
UART_RX_CFG -- requirements
Module: uart_rx_cfg

Interface
REQ-001 SHALL have parameter CLOCK_FREQ, default 50000000, meaning base clock frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 9600, meaning serial bit rate; CLKS_PER_BIT = CLOCK_FREQ/BAUD_RATE (integer division), legal when >= 4.
REQ-003 SHALL have parameter DATA_BITS, default 8, meaning payload bits per frame, legal 5..9.
REQ-004 SHALL have parameter PARITY, default 0, meaning 0 none, 1 odd, 2 even.
REQ-005 SHALL have parameter STOP_BITS, default 1, meaning stop bits checked per frame, legal 1 or 2.
REQ-006 SHALL have port clk, input, 1, meaning the single clock; all logic on its rising edge.
REQ-007 SHALL have port rst, input, 1, meaning reset, asynchronous and active-high.
REQ-008 SHALL have port data_in, input, 1, meaning asynchronous serial line, idle high.
REQ-009 SHALL have port rx_data, output, DATA_BITS, meaning received payload, LSB first on the line.
REQ-010 SHALL have port rx_valid, output, 1, meaning rx_data and error flags hold a frame.
REQ-011 SHALL have port rx_ready, input, 1, meaning consumer accepts; transfer when rx_valid && rx_ready.
REQ-012 SHALL have port parity_err, output, 1, meaning parity mismatch for the held frame (always 0 when PARITY=0).
REQ-013 SHALL have port frame_err, output, 1, meaning a stop bit of the held frame sampled 0.
REQ-014 SHALL have port overrun, output, 1, meaning at least one frame was dropped while rx_valid was high.
REQ-015 SHALL have port busy, output, 1, meaning the FSM is not in IDLE.

Function
REQ-016 SHALL pass data_in through a 2-flop synchroniser; all line decisions use the synchronised value.
REQ-017 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP; PARITY is skipped when PARITY=0.
REQ-018 SHALL hold the bit counter at 0 in IDLE; in other states count 0..CLKS_PER_BIT-1 and wrap; sample tick at count (CLKS_PER_BIT-1)/2, bit-end tick at CLKS_PER_BIT-1.
REQ-019 SHALL leave IDLE for START on the first cycle where the synchronised line is 0.
REQ-020 SHALL return from START to IDLE with no output change if the line samples 1 at the START sample tick (glitch reject); otherwise SHALL enter DATA at the bit-end tick.
REQ-021 SHALL in DATA store the sample into bit index 0..DATA_BITS-1 in order; after the bit-end tick of the last bit, go to PARITY (or STOP).
REQ-022 SHALL in PARITY compare the sample against the computed bit: odd mode requires odd count of ones over data+parity, even mode requires even count; mismatch sets the pending parity flag.
REQ-023 SHALL in STOP sample STOP_BITS bits; any 0 sample sets the pending frame flag.
REQ-024 SHALL on the sample tick of the final stop bit go to IDLE (no wait for bit end) and commit the frame.
REQ-025 Commit with rx_valid=0, or rx_valid=1 with rx_ready=1 in the same cycle: SHALL load rx_data, parity_err, frame_err and set rx_valid=1 on the next edge.
REQ-026 Commit with rx_valid=1 and rx_ready=0: SHALL discard the new frame, keep rx_data/flags unchanged, set overrun=1.
REQ-027 SHALL clear rx_valid and overrun on a handshake not coinciding with a commit; rx_valid SHALL never drop without a handshake.
REQ-028 SHALL deliver frames with parity_err or frame_err set; errors never suppress rx_valid.
REQ-029 SHALL ignore rx_ready while rx_valid=0.

Reset
REQ-030 SHALL on rst=1 immediately force state IDLE, counters 0, synchroniser flops 1, rx_data 0, rx_valid 0, parity_err 0, frame_err 0, overrun 0, busy 0.
REQ-031 SHALL abandon any frame in progress on reset, delivering nothing for it; after release, reception begins only on a new falling edge.

Verification
Bench parameters: CLOCK_FREQ=1000000, BAUD_RATE=100000 (CLKS_PER_BIT=10), DATA_BITS=8 unless stated.
REQ-032 SHALL test PARITY=0, STOP_BITS=1, send 0xA5, rx_ready=1 -> rx_valid one cycle with rx_data=0xA5, all error flags 0.
REQ-033 SHALL test PARITY=2, send 0x03 with parity bit 1 -> rx_data=0x03, parity_err=1; resend with parity 0 -> parity_err=0.
REQ-034 SHALL test STOP_BITS=2, send 0x5A with second stop bit 0 -> rx_data=0x5A, frame_err=1.
REQ-035 SHALL test rx_ready=0, send 0x11 then 0x22 -> rx_data stays 0x11, overrun=1; raise rx_ready -> rx_valid and overrun clear.
REQ-036 SHALL test a 3-cycle low pulse on data_in -> FSM returns to IDLE, rx_valid stays 0.
REQ-037 SHALL test rst asserted mid-DATA of 0xFF, released, then 0x42 sent -> only 0x42 delivered, no error flags.
